pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register for the 5-stage MIPS core.
//  Carries one DW-bit instruction bundle (e.g. res/a3/instr/ao/dr/pc8 for M->W) with valid/ready handshake.
//  Supports stall (backpressure), flush (bubble insert), and an optional 1-entry skid buffer that registers in_ready.
//  Includes a saturating stall-cycle counter for hazard-unit profiling.
//  One instance sits between each pair of stages (F/D, D/E, E/M, M/W).
// PARAMETERS
//  DW         136  payload width in bits (M->W bundle: 3+5+4*32)
//  SKID       1    1: 2-entry skid (in_ready registered); 0: single entry, in_ready combinational from out_ready
//  ZERO_FLUSH 1    1: payload regs zeroed on flush; 0: only valid bits cleared
//  CW         16   stall counter width
// PORTS
//  clk        in   1    clock, all state updates on posedge
//  clr        in   1    synchronous active-high reset
//  flush      in   1    synchronous bubble insert (branch/exception kill)
//  in_valid   in   1    upstream stage holds a valid bundle
//  in_ready   out  1    this stage accepts in_data this cycle
//  in_data    in   DW   upstream bundle
//  out_valid  out  1    out_data holds a valid bundle
//  out_ready  in   1    downstream stage consumes out_data this cycle
//  out_data   out  DW   registered bundle to downstream stage
//  stall_cnt  out  CW   cycles with out_valid=1 && out_ready=0, saturates at 2^CW-1
// BEHAVIOUR
//  Reset (clr=1 at posedge): out_valid=0, out_data=0, skid entry empty/0, stall_cnt=0; in_ready=0 during the clr cycle, 1 the cycle after.
//  Transfer in = in_valid&in_ready; transfer out = out_valid&out_ready; both evaluated on the same edge.
//  Latency: accepted bundle appears on out_data the next cycle (1 cycle, empty stage). No combinational in->out path.
//  SKID=1 states (main entry M, skid entry S):
//   EMPTY (M=0,S=0): in_ready=1; in -> M, go FULL.
//   FULL  (M=1,S=0): in_ready=1; in&out -> M<=in_data, stay; in&!out -> S<=in_data, go SKID; !in&out -> go EMPTY.
//   SKID  (M=1,S=1): in_ready=0; out -> M<=S, S empties, go FULL; else hold.
//   in_ready = !S_valid (register output only, no out_ready dependence).
//  SKID=0: single entry M; in_ready = !M_valid | out_ready; in&out -> replace M same edge.
//  Data ordering: strict FIFO; no bundle dropped or duplicated except by flush/clr.
//  Flush (flush=1, clr=0): M and S valid cleared at that edge; in_data presented that cycle is discarded even if in_valid=1;
//   out_ready that cycle has no effect on state; payloads zeroed iff ZERO_FLUSH=1. in_ready=1 next cycle.
//  clr and flush together: clr wins (identical to reset, incl. stall_cnt=0). flush does not touch stall_cnt.
//  stall_cnt: +1 each cycle out_valid&!out_ready; holds at max; unchanged otherwise.
//  When out_valid=0, out_data holds its last value (0 after reset or ZERO_FLUSH flush); consumers qualify with out_valid.
//  Holding: while out_valid&!out_ready, out_data is stable cycle to cycle.
// TESTING
//  1. clr=1 two cycles, then release -> out_valid=0, out_data=0, stall_cnt=0, in_ready=1 cycle after release.
//  2. Stream A1..A4 with out_ready=1 each cycle -> out_data=A1..A4 on cycles 1..4 after accept, in_ready stays 1.
//  3. SKID=1: send B1,B2,B3, out_ready=0 from cycle 1 -> B1 in M, B2 in S, in_ready=0, B3 held upstream;
//     out_ready=1 -> B1,B2,B3 out in order, stall_cnt equals stalled cycles (e.g. 3).
//  4. State SKID, assert flush with in_valid=1 (C9) -> out_valid=0 next cycle, C9 never emitted,
//     out_data=0 (ZERO_FLUSH=1), in_ready=1.
//  5. CW=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and stays 15; assert flush+clr same cycle -> stall_cnt=0.
//  6. SKID=0: out_ready=0 with M full -> in_ready=0 same cycle; out_ready=1 with in_valid -> replace M in one edge, no bubble.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with valid/ready, flush, optional skid entry and stall counter
//
// Purpose: holds one DW-bit bundle between two pipeline stages. With SKID=1 a second
// entry absorbs the bundle accepted while the downstream stage stalls, so i_in_ready
// is a pure register output. With SKID=0 only the main entry exists and i_in_ready
// looks through to i_out_ready.
//
// Ports:
//   i_clk        clock, all state updates on posedge
//   i_clr        synchronous active-high reset
//   i_flush      synchronous bubble insert (kills both entries)
//   i_in_valid   upstream holds a valid bundle
//   o_in_ready   this stage accepts i_in_data this cycle
//   i_in_data    upstream bundle
//   o_out_valid  o_out_data holds a valid bundle
//   i_out_ready  downstream consumes o_out_data this cycle
//   o_out_data   registered bundle to downstream
//   o_stall_cnt  saturating count of cycles with o_out_valid=1 and i_out_ready=0
module pipe_stage_reg #(
    parameter int DW         = 136,
    parameter int SKID       = 1,
    parameter int ZERO_FLUSH = 1,
    parameter int CW         = 16
) (
    input  logic          i_clk,
    input  logic          i_clr,
    input  logic          i_flush,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [DW-1:0] i_in_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_out_data,
    output logic [CW-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [DW-1:0] r_m_data;
    logic [DW-1:0] r_s_data;
    logic [CW-1:0] r_stall_cnt;

    logic w_m_valid;
    logic w_in_fire;
    logic w_out_fire;
    logic w_stall;
    logic w_m_load_in;
    logic w_m_load_s;
    logic w_s_load;

    assign w_m_valid = (r_state != ST_EMPTY);

    // The skid variant only depends on its own state so that in_ready is a flop
    // output; the single-entry variant lets a consuming downstream free the slot
    // in the same cycle. clr forces not-ready during the reset cycle itself.
    always_comb begin
        if (SKID != 0) begin
            o_in_ready = !i_clr && (r_state != ST_SKID);
        end else begin
            o_in_ready = !i_clr && (!w_m_valid || i_out_ready);
        end
    end

    assign w_in_fire  = i_in_valid && o_in_ready;
    assign w_out_fire = w_m_valid && i_out_ready;
    assign w_stall    = w_m_valid && !i_out_ready;

    // Next state and data-load controls. In FULL, accepting without a consume is
    // only reachable with SKID=1, since SKID=0 accepts in FULL only when out_ready.
    always_comb begin
        w_state_next = r_state;
        w_m_load_in  = 1'b0;
        w_m_load_s   = 1'b0;
        w_s_load     = 1'b0;
        if (i_flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_m_load_in  = 1'b1;
                        w_state_next = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_in_fire && w_out_fire) begin
                        w_m_load_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_s_load     = 1'b1;
                        w_state_next = ST_SKID;
                    end else if (w_out_fire) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (w_out_fire) begin
                        w_m_load_s   = 1'b1;
                        w_state_next = ST_FULL;
                    end
                end
                default: begin
                    w_state_next = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state     <= ST_EMPTY;
            r_m_data    <= '0;
            r_s_data    <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_stall && (r_stall_cnt != {CW{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (i_flush) begin
                if (ZERO_FLUSH != 0) begin
                    r_m_data <= '0;
                    r_s_data <= '0;
                end
            end else begin
                if (w_m_load_in) begin
                    r_m_data <= i_in_data;
                end else if (w_m_load_s) begin
                    r_m_data <= r_s_data;
                end
                if (w_s_load) begin
                    r_s_data <= i_in_data;
                end
            end
        end
    end

    assign o_out_valid = w_m_valid;
    assign o_out_data  = r_m_data;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg (skid and single-entry variants)
module tb_pipe_stage_reg;

    localparam int DW = 136;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;

    logic          rdy_a, ov_a, rdy_b, ov_b;
    logic [DW-1:0] od_a, od_b;
    logic [3:0]    sc_a;
    logic [15:0]   sc_b;

    int total = 0;
    int bad = 0;

    // Reference: each stage is a FIFO of bounded depth; la/lb is what out_data shows.
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic [DW-1:0] la = '0;
    logic [DW-1:0] lb = '0;
    int ca = 0;
    int cb = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DW(DW), .SKID(1), .ZERO_FLUSH(1), .CW(4)) dut_a (
        .i_clk(clk), .i_clr(clr), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(rdy_a),
        .i_in_data(in_data), .o_out_valid(ov_a), .i_out_ready(out_ready), .o_out_data(od_a),
        .o_stall_cnt(sc_a)
    );

    pipe_stage_reg #(.DW(DW), .SKID(0), .ZERO_FLUSH(0), .CW(16)) dut_b (
        .i_clk(clk), .i_clr(clr), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(rdy_b),
        .i_in_data(in_data), .o_out_valid(ov_b), .i_out_ready(out_ready), .o_out_data(od_b),
        .o_stall_cnt(sc_b)
    );

    function automatic logic [DW-1:0] rnd();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    function automatic bit exp_rdy_a();
        return !clr && (qa.size() < 2);
    endfunction

    function automatic bit exp_rdy_b();
        return !clr && ((qb.size() == 0) || out_ready);
    endfunction

    task automatic drive(input bit c, input bit f, input bit v, input logic [DW-1:0] d, input bit r);
        clr = c;
        flush = f;
        in_valid = v;
        in_data = d;
        out_ready = r;
        #1;
    endtask

    task automatic tick();
        bit ra, rb;
        ra = exp_rdy_a();
        rb = exp_rdy_b();
        @(posedge clk);
        if (clr) begin
            qa.delete();
            qb.delete();
            la = '0;
            lb = '0;
            ca = 0;
            cb = 0;
        end else begin
            if (qa.size() > 0 && !out_ready && ca < 15) ca++;
            if (qb.size() > 0 && !out_ready && cb < 65535) cb++;
            if (flush) begin
                qa.delete();
                la = '0;
                qb.delete();
            end else begin
                if (qa.size() > 0 && out_ready) void'(qa.pop_front());
                if (in_valid && ra) qa.push_back(in_data);
                if (qa.size() > 0) la = qa[0];
                if (qb.size() > 0 && out_ready) void'(qb.pop_front());
                if (in_valid && rb) qb.push_back(in_data);
                if (qb.size() > 0) lb = qb[0];
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, rnd(), 1'b0);
        tick();
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b1, rnd(), 1'b1);
            total++;
            if (rdy_a !== 1'b0 || rdy_b !== 1'b0) begin
                bad++;
                $display("FAIL reset_in_ready got a=%b b=%b want 0 0", rdy_a, rdy_b);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, rnd(), 1'b0);
        total++;
        if (ov_a !== 1'b0 || od_a !== '0 || sc_a !== 4'd0 || rdy_a !== 1'b1) begin
            bad++;
            $display("FAIL reset_state_a got v=%b d=%h cnt=%0d rdy=%b want 0 0 0 1", ov_a, od_a, sc_a, rdy_a);
        end
        total++;
        if (ov_b !== 1'b0 || od_b !== '0 || sc_b !== 16'd0 || rdy_b !== 1'b1) begin
            bad++;
            $display("FAIL reset_state_b got v=%b d=%h cnt=%0d rdy=%b want 0 0 0 1", ov_b, od_b, sc_b, rdy_b);
        end
    endtask

    task automatic test_stream();
        logic [DW-1:0] av[4];
        for (int i = 0; i < 4; i++) av[i] = rnd();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, k < 4, av[k % 4], 1'b1);
            if (k < 4) begin
                total++;
                if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
                    bad++;
                    $display("FAIL stream_ready k=%0d got a=%b b=%b want 1 1", k, rdy_a, rdy_b);
                end
            end
            if (k >= 1 && k <= 4) begin
                total++;
                if (ov_a !== 1'b1 || od_a !== av[k-1] || ov_b !== 1'b1 || od_b !== av[k-1]) begin
                    bad++;
                    $display("FAIL stream_data k=%0d got a=%b/%h b=%b/%h want 1/%h", k, ov_a, od_a, ov_b, od_b, av[k-1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_skid_stall();
        logic [DW-1:0] bv[3];
        logic [DW-1:0] got[$];
        int idx = 0;
        bit ok;
        bit r;
        for (int i = 0; i < 3; i++) bv[i] = rnd();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            r = !(k >= 1 && k <= 3);
            drive(1'b0, 1'b0, idx < 3, bv[idx % 3], r);
            total++;
            if ({rdy_a, ov_a, od_a, sc_a} !== {exp_rdy_a(), qa.size() > 0, la, ca[3:0]}) begin
                bad++;
                $display("FAIL skid_model k=%0d got rdy=%b v=%b d=%h cnt=%0d want rdy=%b v=%b d=%h cnt=%0d",
                         k, rdy_a, ov_a, od_a, sc_a, exp_rdy_a(), qa.size() > 0, la, ca);
            end
            if (k == 2) begin
                total++;
                if (rdy_a !== 1'b0) begin
                    bad++;
                    $display("FAIL skid_full_ready got %b want 0", rdy_a);
                end
            end
            if (ov_a && out_ready) got.push_back(od_a);
            if (in_valid && rdy_a) idx++;
            tick();
        end
        ok = (got.size() == 3);
        if (ok) for (int i = 0; i < 3; i++) ok = ok && (got[i] === bv[i]);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL skid_order got %0d bundles want 3 in order", got.size());
        end
        total++;
        if (sc_a !== 4'd3) begin
            bad++;
            $display("FAIL skid_stall_cnt got %0d want 3", sc_a);
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] c1, c2, c9;
        c1 = rnd();
        c2 = rnd();
        c9 = rnd();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, c1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, c2, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b1, c9, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b0, rnd(), 1'b1);
            total++;
            if (ov_a !== 1'b0 || od_a !== '0 || rdy_a !== 1'b1) begin
                bad++;
                $display("FAIL flush_a k=%0d got v=%b d=%h rdy=%b want 0 0 1", k, ov_a, od_a, rdy_a);
            end
            total++;
            if (ov_b !== 1'b0 || od_b !== c1 || rdy_b !== 1'b1) begin
                bad++;
                $display("FAIL flush_b k=%0d got v=%b d=%h rdy=%b want 0 %h 1", k, ov_b, od_b, rdy_b, c1);
            end
            tick();
        end
    endtask

    task automatic test_saturate();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, rnd(), 1'b0);
        tick();
        for (int i = 0; i < 22; i++) begin
            drive(1'b0, 1'b0, 1'b0, rnd(), 1'b0);
            total++;
            if (sc_a !== ((i < 15) ? i[3:0] : 4'd15)) begin
                bad++;
                $display("FAIL sat_cnt i=%0d got %0d want %0d", i, sc_a, (i < 15) ? i : 15);
            end
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, rnd(), 1'b0);
        total++;
        if (sc_b !== 16'd22) begin
            bad++;
            $display("FAIL sat_cnt_wide got %0d want 22", sc_b);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, rnd(), 1'b0);
        total++;
        if (sc_a !== 4'd0 || sc_b !== 16'd0 || ov_a !== 1'b0 || od_a !== '0 || od_b !== '0) begin
            bad++;
            $display("FAIL clr_flush got cnt=%0d/%0d v=%b da=%h db=%h want 0/0 0 0 0", sc_a, sc_b, ov_a, od_a, od_b);
        end
    endtask

    task automatic test_noskid();
        logic [DW-1:0] e1, e2, e3;
        e1 = rnd();
        e2 = rnd();
        e3 = rnd();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, e1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, e2, 1'b0);
        total++;
        if (rdy_b !== 1'b0 || ov_b !== 1'b1 || od_b !== e1) begin
            bad++;
            $display("FAIL noskid_block got rdy=%b v=%b d=%h want 0 1 %h", rdy_b, ov_b, od_b, e1);
        end
        tick();
        drive(1'b0, 1'b0, 1'b1, e2, 1'b1);
        total++;
        if (rdy_b !== 1'b1) begin
            bad++;
            $display("FAIL noskid_passthru_ready got %b want 1", rdy_b);
        end
        tick();
        drive(1'b0, 1'b0, 1'b1, e3, 1'b1);
        total++;
        if (ov_b !== 1'b1 || od_b !== e2 || rdy_b !== 1'b1) begin
            bad++;
            $display("FAIL noskid_replace got v=%b d=%h rdy=%b want 1 %h 1", ov_b, od_b, rdy_b, e2);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, rnd(), 1'b1);
        total++;
        if (ov_b !== 1'b1 || od_b !== e3) begin
            bad++;
            $display("FAIL noskid_last got v=%b d=%h want 1 %h", ov_b, od_b, e3);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, rnd(), 1'b1);
        total++;
        if (ov_b !== 1'b0 || od_b !== e3) begin
            bad++;
            $display("FAIL noskid_hold got v=%b d=%h want 0 %h", ov_b, od_b, e3);
        end
    endtask

    task automatic test_random();
        bit c, f, v, r;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            c = ($urandom % 64) == 0;
            f = ($urandom % 32) == 0;
            v = ($urandom % 2) == 1;
            r = ($urandom % 10) < 6;
            drive(c, f, v, rnd(), r);
            total++;
            if ({rdy_a, ov_a, od_a, sc_a} !== {exp_rdy_a(), qa.size() > 0, la, ca[3:0]}) begin
                bad++;
                $display("FAIL rand_a k=%0d got rdy=%b v=%b d=%h cnt=%0d want rdy=%b v=%b d=%h cnt=%0d",
                         k, rdy_a, ov_a, od_a, sc_a, exp_rdy_a(), qa.size() > 0, la, ca);
            end
            total++;
            if ({rdy_b, ov_b, od_b, sc_b} !== {exp_rdy_b(), qb.size() > 0, lb, cb[15:0]}) begin
                bad++;
                $display("FAIL rand_b k=%0d got rdy=%b v=%b d=%h cnt=%0d want rdy=%b v=%b d=%h cnt=%0d",
                         k, rdy_b, ov_b, od_b, sc_b, exp_rdy_b(), qb.size() > 0, lb, cb);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid_stall();
        test_flush();
        test_saturate();
        test_noskid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
